// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   Pipeline MEM stage: a 2^ADDR_W x 16 synchronous data RAM plus the MEM/WB
//   pipeline register.
//   - Stores write the RAM at the edge that ends their IDLE cycle, with no stall.
//   - Loads take two cycles. In the IDLE cycle the read is issued, stall is
//     raised, and a bubble enters MEM/WB. In the LOAD cycle the RAM word is
//     captured together with the held control and data.
//   - Non-memory ops pass through in one cycle.
//
// Optional build macro:
//   MEM_RANGE_CHECK_EN
//     Defined: an access whose aluresult[15:ADDR_W] is nonzero is suppressed
//     and flagged on memerr for one output cycle.
//     Undefined: the upper address bits are ignored (the address wraps) and
//     memerr stays 0.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   branch, zero       branch decision inputs; pcsrc = branch & zero in IDLE
//   memread, memwrite  memory access controls
//   regwrite, memtoreg writeback controls, forwarded to MEM/WB
//   aluresult[15:0]    memory word address, or ALU result to pass through
//   data_to_mem[15:0]  store data
//   regdst[3:0]        destination register number
//   stall              combinational; asks upstream to hold its inputs
//   pcsrc              combinational branch-taken select
//   regwriteout, memtoregout, validout, readdataout, aluresultout,
//   regdstout          MEM/WB register outputs
//   memerr             registered out-of-range access flag
// ---------------------------------------------------------------------------
module mem_access_stage #(
   parameter int ADDR_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        branch,
   input  logic        memread,
   input  logic        memwrite,
   input  logic        zero,
   input  logic        regwrite,
   input  logic        memtoreg,
   input  logic [15:0] aluresult,
   input  logic [15:0] data_to_mem,
   input  logic [3:0]  regdst,
   output logic        stall,
   output logic        pcsrc,
   output logic        regwriteout,
   output logic        memtoregout,
   output logic        validout,
   output logic [15:0] readdataout,
   output logic [15:0] aluresultout,
   output logic [3:0]  regdstout,
   output logic        memerr
);

   localparam int DATA_W = 16;
   localparam int DEPTH  = 2 ** ADDR_W;

   typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

   state_t r_state, w_state_nxt;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata_p1;
   logic [ADDR_W-1:0] w_addr;

   logic              w_oob;
   logic              w_ld_start;
   logic              w_ram_we;
   logic              w_ram_re;

   logic              w_valid_nxt;
   logic              w_regwrite_nxt;
   logic              w_memtoreg_nxt;
   logic [DATA_W-1:0] w_rdata_nxt;
   logic [DATA_W-1:0] w_alu_nxt;
   logic [3:0]        w_regdst_nxt;
   logic              w_memerr_nxt;

   assign w_addr = aluresult[ADDR_W-1:0];

`ifdef MEM_RANGE_CHECK_EN
   assign w_oob = (memread | memwrite) & (|aluresult[15:ADDR_W]);
`else
   assign w_oob = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_ld_start     = 1'b0;
      stall          = 1'b0;
      pcsrc          = 1'b0;
      w_ram_we       = 1'b0;
      w_ram_re       = 1'b0;
      w_valid_nxt    = 1'b1;
      w_regwrite_nxt = regwrite;
      w_memtoreg_nxt = memtoreg;
      w_rdata_nxt    = '0;
      w_alu_nxt      = aluresult;
      w_regdst_nxt   = regdst;
      w_memerr_nxt   = 1'b0;

      case (r_state)
         IDLE: begin
            pcsrc = branch & zero;
            // A simultaneous read and write is treated as a store only.
            w_ld_start = memread & ~memwrite & ~w_oob;
            stall      = w_ld_start;
            w_ram_we   = memwrite & ~w_oob & ~rst;
            w_ram_re   = w_ld_start & ~rst;
            if (w_ld_start) begin
               w_state_nxt    = LOAD;
               w_valid_nxt    = 1'b0;
               w_regwrite_nxt = 1'b0;
               w_memtoreg_nxt = 1'b0;
               w_alu_nxt      = '0;
               w_regdst_nxt   = '0;
            end else if (w_oob) begin
               w_regwrite_nxt = 1'b0;
               w_memerr_nxt   = 1'b1;
            end
         end
         LOAD: begin
            // Upstream has held the load's inputs, so they pair with the RAM word.
            w_state_nxt = IDLE;
            w_rdata_nxt = r_rdata_p1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // ---- RAM access: write and read-issue edge (p0 -> p1) ----
   always_ff @(posedge clk) begin
      if (w_ram_we) r_mem[w_addr] <= data_to_mem;
      if (w_ram_re) r_rdata_p1   <= r_mem[w_addr];
   end

   // ---- MEM/WB register ----
   always_ff @(posedge clk) begin
      if (rst) begin
         validout     <= 1'b0;
         regwriteout  <= 1'b0;
         memtoregout  <= 1'b0;
         readdataout  <= '0;
         aluresultout <= '0;
         regdstout    <= '0;
         memerr       <= 1'b0;
      end else begin
         validout     <= w_valid_nxt;
         regwriteout  <= w_regwrite_nxt;
         memtoregout  <= w_memtoreg_nxt;
         readdataout  <= w_rdata_nxt;
         aluresultout <= w_alu_nxt;
         regdstout    <= w_regdst_nxt;
         memerr       <= w_memerr_nxt;
      end
   end

endmodule
